sync_memory: RTL and testbench

SYNC_MEMORY -- requirements
Module: sync_memory

---
 rtl/mem_pkg.sv | 12 +
 rtl/sync_memory_array.sv | 49 ++++
 rtl/sync_memory.sv | 108 ++++++++++
 tb/tb_sync_memory.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the synchronous memory block.
package mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

endpackage

// File: rtl/sync_memory_array.sv
// Single-port word storage with byte-enable writes and a registered, write-first read port.
module sync_memory_array
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic                    clr,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int BW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] merged_word;

  always_comb begin
    cur_word    = mem[addr];
    merged_word = cur_word;
    for (int k = 0; k < BW; k++) begin
      if (be[k]) merged_word[8*k +: 8] = wdata[8*k +: 8];
    end
  end

  // Storage has no reset; contents come only from the init sweep.
  always_ff @(posedge clk) begin
    for (int k = 0; k < BW; k++) begin
      if (wr_en && be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= wr_en ? merged_word : cur_word;
    end
  end

endmodule

// File: rtl/sync_memory.sv
// Memory with a power-on init sweep followed by a one-cycle-latency request/response port.
// Handshake: a request is taken on a rising edge where req_valid && req_ready; exactly one
// rsp_valid pulse follows in the next cycle, and responses are never back-pressured.
module sync_memory
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int INIT_MODE  = 1,
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [AW-1:0]           req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    init_busy,
  output state_t                  dbg_state
);

  state_t                state;
  logic [AW-1:0]         cnt;
  logic                  ready_q;
  logic                  busy_q;
  logic                  valid_q;
  logic                  err_q;

  logic                  accept;
  logic                  oob;
  logic                  in_init;
  logic                  arr_wr_en;
  logic                  arr_rd_en;
  logic                  arr_clr;
  logic [AW-1:0]         arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH/8-1:0] arr_be;
  logic [DATA_WIDTH-1:0] init_word;

  assign in_init   = (state == INIT);
  assign accept    = req_valid && ready_q && !rst;
  assign oob       = 32'(req_addr) >= 32'(MEM_DEPTH);
  assign init_word = (INIT_MODE == INIT_INDEX) ? DATA_WIDTH'(cnt) : '0;

  assign arr_wr_en = (in_init && !rst) || (accept && req_we && !oob);
  assign arr_rd_en = accept && !oob;
  assign arr_clr   = accept && oob;
  assign arr_addr  = in_init ? cnt : req_addr;
  assign arr_wdata = in_init ? init_word : req_wdata;
  assign arr_be    = in_init ? '1 : req_be;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      cnt     <= '0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= accept;
      if (accept) err_q <= oob;
      case (state)
        INIT: begin
          if (cnt == AW'(MEM_DEPTH - 1)) begin
            state   <= RUN;
            cnt     <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN:     ;
        default: state <= INIT;
      endcase
    end
  end

  sync_memory_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_WIDTH(AW)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .wr_en(arr_wr_en),
    .rd_en(arr_rd_en),
    .clr  (arr_clr),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .be   (arr_be),
    .rdata(rsp_rdata)
  );

  // A reset in the response cycle cancels that response.
  assign rsp_valid = valid_q && !rst;
  assign rsp_err   = err_q;
  assign req_ready = ready_q;
  assign init_busy = busy_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_sync_memory.sv
// Bench for sync_memory: reference model on the default instance plus directed checks on
// a 48-word instance and a zero-fill instance.
module tb_sync_memory;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instance A: 64 words, index fill ----------------
  logic        a_rst, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_err, a_init_busy;
  logic [5:0]  a_req_addr;
  logic [31:0] a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;
  state_t      a_state;

  sync_memory #(.DATA_WIDTH(32), .MEM_DEPTH(64), .INIT_MODE(1)) dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .init_busy(a_init_busy), .dbg_state(a_state)
  );

  // ---------------- instance B: 48 words, index fill ----------------
  logic        b_rst, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err, b_init_busy;
  logic [5:0]  b_req_addr;
  logic [31:0] b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;
  state_t      b_state;

  sync_memory #(.DATA_WIDTH(32), .MEM_DEPTH(48), .INIT_MODE(1)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .init_busy(b_init_busy), .dbg_state(b_state)
  );

  // ---------------- instance C: 64 words, zero fill ----------------
  logic        c_rst, c_req_valid, c_req_ready, c_req_we, c_rsp_valid, c_rsp_err, c_init_busy;
  logic [5:0]  c_req_addr;
  logic [31:0] c_req_wdata, c_rsp_rdata;
  logic [3:0]  c_req_be;
  state_t      c_state;

  sync_memory #(.DATA_WIDTH(32), .MEM_DEPTH(64), .INIT_MODE(0)) dut_c (
    .clk(clk), .rst(c_rst), .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req_we(c_req_we), .req_addr(c_req_addr), .req_wdata(c_req_wdata), .req_be(c_req_be),
    .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata), .rsp_err(c_rsp_err),
    .init_busy(c_init_busy), .dbg_state(c_state)
  );

  // ---------------- reference model for instance A ----------------
  logic [31:0] m_mem [64];
  int          m_left  = 0;
  bit          m_on    = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_err   = 1'b0;
  logic [31:0] m_data  = '0;

  always @(posedge clk) begin
    if (a_rst) begin
      m_on = 1'b1; m_left = 64; m_valid = 1'b0; m_err = 1'b0; m_data = '0;
    end else if (m_left > 0) begin
      m_left--;
      m_valid = 1'b0;
      if (m_left == 0) for (int i = 0; i < 64; i++) m_mem[i] = 32'(i);
    end else if (a_req_valid) begin
      m_valid = 1'b1;
      m_err   = 1'b0;
      if (a_req_we)
        for (int k = 0; k < 4; k++)
          if (a_req_be[k]) m_mem[a_req_addr][8*k +: 8] = a_req_wdata[8*k +: 8];
      m_data = m_mem[a_req_addr];
    end else begin
      m_valid = 1'b0;
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_on) begin
      chk("a_rsp_valid", 64'(a_rsp_valid), 64'(m_valid && !a_rst));
      chk("a_rsp_err",   64'(a_rsp_err),   64'(m_err));
      chk("a_rsp_rdata", 64'(a_rsp_rdata), 64'(m_data));
      chk("a_req_ready", 64'(a_req_ready), 64'(m_left == 0));
      chk("a_init_busy", 64'(a_init_busy), 64'(m_left > 0));
    end
  end

  logic [31:0] got_d [$];
  always @(negedge clk) if (a_rsp_valid === 1'b1) got_d.push_back(a_rsp_rdata);

  // ---------------- driver tasks ----------------
  task automatic a_drive(input logic we, input logic [5:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_be = be;
    @(posedge clk); #1;
  endtask

  task automatic a_idle_settle();
    a_req_valid = 1'b0; a_req_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string name, input logic [31:0] exp);
    if (got_d.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: got no response expected %0h", name, exp);
    end else begin
      chk(name, 64'(got_d.pop_front()), 64'(exp));
    end
  endtask

  task automatic a_wait_init(input string name, input int exp_len);
    int n = 0;
    while (a_init_busy === 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 64'(n), 64'(exp_len));
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0;
    c_req_valid = 0; c_req_we = 0; c_req_addr = 0; c_req_wdata = 0; c_req_be = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(a_init_busy), 64'd1);
    chk("reset_ready", 64'(a_req_ready), 64'd0);
    chk("reset_rdata", 64'(a_rsp_rdata), 64'd0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // Requests during INIT are ignored; reset at cycle 20 restarts the sweep.
    a_req_valid = 1'b1; a_req_addr = 6'd5;
    repeat (20) @(posedge clk);
    #1 a_rst = 1'b1;
    @(posedge clk); #1 a_rst = 1'b0;
    a_wait_init("init_len_after_restart", 64);
    a_req_valid = 1'b0;
    chk("no_rsp_during_init", 64'(got_d.size()), 64'd0);
    got_d.delete();

    a_drive(1'b0, 6'd5, '0, '0);
    a_idle_settle();
    pop_chk("read5", 32'd5);

    for (int i = 0; i < 8; i++) a_drive(1'b0, 6'(i), '0, '0);
    a_idle_settle();
    chk("burst_count", 64'(got_d.size()), 64'd8);
    for (int i = 0; i < 8; i++) pop_chk("burst_data", 32'(i));

    a_drive(1'b1, 6'd3, 32'hAABBCCDD, 4'b0101);
    a_drive(1'b0, 6'd3, '0, '0);
    a_drive(1'b1, 6'd4, 32'hFFFFFFFF, 4'b0000);
    a_drive(1'b0, 6'd4, '0, '0);
    a_drive(1'b1, 6'd63, 32'hCAFEF00D, 4'b1111);
    a_drive(1'b0, 6'd63, '0, '0);
    a_drive(1'b1, 6'd10, 32'h11223344, 4'b1000);
    a_idle_settle();
    pop_chk("write_merge", 32'h00BB00DD);
    pop_chk("read_after_write", 32'h00BB00DD);
    pop_chk("be_zero_write", 32'd4);
    pop_chk("be_zero_read", 32'd4);
    pop_chk("full_write", 32'hCAFEF00D);
    pop_chk("full_read", 32'hCAFEF00D);
    pop_chk("top_byte_write", 32'h1100000A);

    // Reset in the response cycle drops the response and re-runs the sweep.
    a_drive(1'b1, 6'd7, 32'h12345678, 4'b1111);
    a_req_valid = 1'b0; a_rst = 1'b1;
    @(negedge clk);
    chk("rst_discard_valid", 64'(a_rsp_valid), 64'd0);
    @(posedge clk); #1 a_rst = 1'b0;
    got_d.delete();
    a_wait_init("init_len_rerun", 64);
    a_drive(1'b0, 6'd7, '0, '0);
    a_idle_settle();
    pop_chk("reinit_read7", 32'd7);

    // Instance B: out-of-range then top in-range word.
    b_req_valid = 1'b1; b_req_addr = 6'd50;
    @(posedge clk); #1 b_req_addr = 6'd47;
    @(negedge clk);
    chk("b_oob_valid", 64'(b_rsp_valid), 64'd1);
    chk("b_oob_err", 64'(b_rsp_err), 64'd1);
    chk("b_oob_rdata", 64'(b_rsp_rdata), 64'd0);
    @(posedge clk); #1 b_req_valid = 1'b0;
    @(negedge clk);
    chk("b_read47_valid", 64'(b_rsp_valid), 64'd1);
    chk("b_read47_err", 64'(b_rsp_err), 64'd0);
    chk("b_read47_rdata", 64'(b_rsp_rdata), 64'd47);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_hold_valid", 64'(b_rsp_valid), 64'd0);
    chk("b_hold_rdata", 64'(b_rsp_rdata), 64'd47);

    // Instance C: zero fill everywhere.
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1 c_req_valid = 1'b1; c_req_addr = 6'(i);
      @(posedge clk); #1 c_req_valid = 1'b0;
      @(negedge clk);
      chk("c_zero_valid", 64'(c_rsp_valid), 64'd1);
      chk("c_zero_rdata", 64'(c_rsp_rdata), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
